// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-port memory arbiter.
package arb_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StAck  = 2'd2
  } arb_state_t;

  // Encoded requester index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4x12bit.sv
// Four-input 12-bit multiplexer.
module mux4x12bit (
  input  logic [11:0] in0,
  input  logic [11:0] in1,
  input  logic [11:0] in2,
  input  logic [11:0] in3,
  input  logic [1:0]  sel,
  output logic [11:0] out
);

  // Select one of four inputs.
  always_comb begin
    unique case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/mux4x8bit.sv
// Four-input 8-bit multiplexer.
module mux4x8bit (
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [1:0] sel,
  output logic [7:0] out
);

  // Select one of four inputs.
  always_comb begin
    unique case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: searches upward from last_gnt+1, wrapping mod N_REQ.
module rr_picker
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_gnt,
  output logic [SEL_W-1:0] winner,
  output logic             valid
);

  // First set request bit after last_gnt; last_gnt itself is the lowest priority.
  always_comb begin
    logic [SEL_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = last_gnt + SEL_W'(i);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between four requesters.
// Optional busy-wait timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0] req_wdata,
  input  logic [N_REQ-1:0]             req_we,
  input  logic                         mem_ready,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [N_REQ-1:0]             gnt,
  output logic [SEL_W-1:0]             sel,
  output logic [N_REQ-1:0]             ack,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         err,
  output logic                         busy
);

  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d, last_gnt_q, last_gnt_d, pick_idx;
  logic              pick_valid;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;
  logic              timeout;

  rr_picker u_picker (
    .req      (req),
    .last_gnt (last_gnt_q),
    .winner   (pick_idx),
    .valid    (pick_valid)
  );

  mux4x12bit u_addr_mux (
    .in0 (req_addr[0]),
    .in1 (req_addr[1]),
    .in2 (req_addr[2]),
    .in3 (req_addr[3]),
    .sel (sel_q),
    .out (mux_addr)
  );

  mux4x8bit u_wdata_mux (
    .in0 (req_wdata[0]),
    .in1 (req_wdata[1]),
    .in2 (req_wdata[2]),
    .in3 (req_wdata[3]),
    .sel (sel_q),
    .out (mux_wdata)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign timeout = (cnt_q == CntLast);

  // Counter runs only in BUSY and sits at zero elsewhere, so it is clear on BUSY entry.
  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (state_q == StBusy) begin
      cnt_d = cnt_q + 8'd1;
      err_d = !mem_ready && timeout;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = (state_q == StAck) && err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state and memory strobes; ack is a one-hot copy of the held grant in ACK.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    rsp_d      = rsp_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    ack        = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          sel_d      = pick_idx;
          last_gnt_d = pick_idx;
          gnt_d      = idx_to_onehot(pick_idx);
          state_d    = StBusy;
        end
      end
      StBusy: begin
        mem_en = 1'b1;
        mem_we = req_we[sel_q];
        if (mem_ready) begin
          rsp_d   = mem_rdata;
          state_d = StAck;
        end else if (timeout) begin
          rsp_d   = '0;
          state_d = StAck;
        end
      end
      StAck: begin
        ack     = gnt_q;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and grant registers; last_gnt resets to 3 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      last_gnt_q <= SEL_W'(N_REQ - 1);
      gnt_q      <= '0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      rsp_q      <= rsp_d;
    end
  end

  assign mem_addr  = mem_en ? mux_addr : '0;
  assign mem_wdata = mem_en ? mux_wdata : '0;
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign rsp_data  = rsp_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases and
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TimeoutCyc = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  localparam int PIdle = 0;
  localparam int PBusy = 1;
  localparam int PAck  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       req;
  logic [3:0][11:0] req_addr;
  logic [3:0][7:0]  req_wdata;
  logic [3:0]       req_we;
  logic             mem_ready;
  logic [7:0]       mem_rdata;
  logic             mem_en, mem_we, err, busy;
  logic [11:0]      mem_addr;
  logic [7:0]       mem_wdata, rsp_data;
  logic [3:0]       gnt, ack;
  logic [1:0]       sel;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TimeoutCyc)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .gnt       (gnt),
    .sel       (sel),
    .ack       (ack),
    .rsp_data  (rsp_data),
    .err       (err),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which requester owns the port, in which phase of its access.
  int         m_phase = PIdle;
  int         m_owner = 0;
  int         m_last  = 3;
  int         m_wait  = 0;
  logic [7:0] m_rsp   = 8'h00;
  bit         m_err   = 1'b0;
  bit         m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [3:0] owner_oh;
    if (!m_valid) return;
    owner_oh = 4'(1 << m_owner);
    chk("busy",   32'(busy),     32'(m_phase != PIdle));
    chk("gnt",    32'(gnt),      (m_phase == PIdle) ? 32'd0 : 32'(owner_oh));
    chk("sel",    32'(sel),      32'(m_owner));
    chk("ack",    32'(ack),      (m_phase == PAck) ? 32'(owner_oh) : 32'd0);
    chk("mem_en", 32'(mem_en),   32'(m_phase == PBusy));
    chk("mem_we", 32'(mem_we),   32'((m_phase == PBusy) && req_we[m_owner]));
    chk("err",    32'(err),      32'((m_phase == PAck) && m_err));
    chk("rsp",    32'(rsp_data), 32'(m_rsp));
    if (m_phase == PBusy) begin
      chk("addr",  32'(mem_addr),  32'(req_addr[m_owner]));
      chk("wdata", 32'(mem_wdata), 32'(req_wdata[m_owner]));
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = PIdle; m_owner = 0; m_last = 3; m_rsp = 8'h00; m_err = 1'b0; m_wait = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        PIdle: begin
          for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (req[c]) begin
              m_owner = c; m_last = c; m_phase = PBusy; m_wait = 0;
              break;
            end
          end
        end
        PBusy: begin
          m_wait++;
          if (mem_ready) begin
            m_rsp = mem_rdata; m_err = 1'b0; m_phase = PAck;
          end else if (TimeoutOn && m_wait == TimeoutCyc) begin
            m_rsp = 8'h00; m_err = 1'b1; m_phase = PAck;
          end
        end
        default: m_phase = PIdle;
      endcase
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] we,
                       input logic mr, input logic [7:0] rd);
    rst = r; req = rq; req_we = we; mem_ready = mr; mem_rdata = rd;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick(input logic r, input logic [3:0] rq, input logic [3:0] we,
                      input logic mr, input logic [7:0] rd);
    drive(r, rq, we, mr, rd);
    @(negedge clk);
    model_check();
    finish_cycle();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       mr;
    logic [7:0] rd;
    logic [3:0] e_gnt;
    logic [3:0] e_ack;
    logic       e_busy;
    logic       e_en;
    logic [7:0] e_rsp;
  } vec_t;

  vec_t tbl[19];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : main
    int seen;
    int n;

    // Single read, ready on 3rd BUSY cycle; then 4 back-to-back requests with ready each cycle.
    tbl[0]  = '{4'b0001, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{4'b0001, 1'b0, 8'h00, 4'b0001, 4'b0000, 1'b1, 1'b1, 8'h00};
    tbl[2]  = '{4'b0000, 1'b0, 8'h00, 4'b0001, 4'b0000, 1'b1, 1'b1, 8'h00};
    tbl[3]  = '{4'b0000, 1'b1, 8'hA5, 4'b0001, 4'b0000, 1'b1, 1'b1, 8'h00};
    tbl[4]  = '{4'b0000, 1'b1, 8'h5A, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'hA5};
    tbl[5]  = '{4'b0000, 1'b1, 8'h5A, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5};
    tbl[6]  = '{4'b1111, 1'b1, 8'h11, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5};
    tbl[7]  = '{4'b1111, 1'b1, 8'h11, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'hA5};
    tbl[8]  = '{4'b1111, 1'b1, 8'h22, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'h11};
    tbl[9]  = '{4'b1111, 1'b1, 8'h33, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h11};
    tbl[10] = '{4'b1111, 1'b1, 8'h44, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'h11};
    tbl[11] = '{4'b1111, 1'b1, 8'h55, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'h44};
    tbl[12] = '{4'b1111, 1'b1, 8'h66, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h44};
    tbl[13] = '{4'b1111, 1'b1, 8'h77, 4'b1000, 4'b0000, 1'b1, 1'b1, 8'h44};
    tbl[14] = '{4'b1111, 1'b1, 8'h88, 4'b1000, 4'b1000, 1'b1, 1'b0, 8'h77};
    tbl[15] = '{4'b1111, 1'b1, 8'h99, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h77};
    tbl[16] = '{4'b1111, 1'b1, 8'hAA, 4'b0001, 4'b0000, 1'b1, 1'b1, 8'h77};
    tbl[17] = '{4'b0000, 1'b0, 8'h00, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'hAA};
    tbl[18] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hAA};

    req_addr  = '{12'hABC, 12'h789, 12'h456, 12'h123};
    req_wdata = '{8'h40, 8'h30, 8'h20, 8'h10};
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00);
    @(posedge clk);
    #1;

    // Reset; the second cycle checks reset values against the model.
    tick(1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00);
    tick(1'b1, 4'b1111, 4'b0000, 1'b1, 8'hFF);

    for (int i = 0; i < 19; i++) begin
      drive(1'b0, tbl[i].req, 4'b0000, tbl[i].mr, tbl[i].rd);
      @(negedge clk);
      model_check();
      chk($sformatf("tbl%0d_gnt", i),  32'(gnt),      32'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_ack", i),  32'(ack),      32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_busy", i), 32'(busy),     32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_en", i),   32'(mem_en),   32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_rsp", i),  32'(rsp_data), 32'(tbl[i].e_rsp));
      if (tbl[i].e_busy && tbl[i].e_en && tbl[i].e_gnt == 4'b0001)
        chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'h123);
      finish_cycle();
    end

    // Requester 2 write: strobes and data only while BUSY.
    req_addr[2]  = 12'hFFF;
    req_wdata[2] = 8'h3C;
    tick(1'b0, 4'b0100, 4'b0100, 1'b0, 8'h00);
    chk("wr_busy_we",    32'(mem_we),    32'd1);
    chk("wr_busy_addr",  32'(mem_addr),  32'hFFF);
    chk("wr_busy_wdata", 32'(mem_wdata), 32'h3C);
    tick(1'b0, 4'b0000, 4'b0100, 1'b0, 8'h00);
    tick(1'b0, 4'b0000, 4'b0100, 1'b1, 8'hEE);
    chk("wr_ack_we", 32'(mem_we), 32'd0);
    chk("wr_ack_en", 32'(mem_en), 32'd0);
    tick(1'b0, 4'b0000, 4'b0100, 1'b0, 8'h00);
    chk("wr_idle_we", 32'(mem_we), 32'd0);

    // Reset mid-BUSY aborts without ack; next grant restarts at requester 0.
    tick(1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00);
    chk("pre_rst_gnt", 32'(gnt), 32'b1000);
    tick(1'b1, 4'b1111, 4'b0000, 1'b1, 8'h77);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_ack",  32'(ack),      32'd0);
    chk("rst_gnt",  32'(gnt),      32'd0);
    chk("rst_rsp",  32'(rsp_data), 32'd0);
    tick(1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00);
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    tick(1'b0, 4'b0000, 4'b0000, 1'b1, 8'h12);
    tick(1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);

    // Memory never ready: timeout after TimeoutCyc BUSY cycles, or wait forever.
    tick(1'b0, 4'b0001, 4'b0000, 1'b0, 8'h00);
    seen = 0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 4'b0000, 4'b0000, 1'b0, 8'hC3);
      if (ack != 4'b0000) begin
        seen = 1;
        n = i;
        break;
      end
    end
    if (TimeoutOn) begin
      chk("to_seen",   32'(seen),     32'd1);
      chk("to_cycles", 32'(n),        32'(TimeoutCyc));
      chk("to_err",    32'(err),      32'd1);
      chk("to_rsp",    32'(rsp_data), 32'd0);
      tick(1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    end else begin
      chk("noto_seen", 32'(seen), 32'd0);
      chk("noto_busy", 32'(busy), 32'd1);
      chk("noto_err",  32'(err),  32'd0);
      tick(1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) begin
        req_addr[k]  = 12'($urandom);
        req_wdata[k] = 8'($urandom);
      end
      tick(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 2) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
